// File: rtl/sudoku_game_engine.sv
// Sudoku game engine: load a puzzle, take validated cell writes, undo them, and scan rows/cols/boxes.
// Define SUDOKU_UNDO_EN to build the undo history buffer; without it undo_req is ignored.
module sudoku_game_engine #(
  parameter int BOX        = 3,
  parameter int DW         = 4,
  parameter int UNDO_DEPTH = 16,
  parameter int HOLD       = 500000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BOX*BOX*BOX*BOX*DW-1:0] init_board,
  input  logic [BOX*BOX*BOX*BOX-1:0]    init_blank,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [3:0]                    wr_row,
  input  logic [3:0]                    wr_col,
  input  logic [DW-1:0]                 wr_data,
  input  logic                          undo_req,
  output logic [BOX*BOX*BOX*BOX*DW-1:0] board,
  output logic [BOX*BOX*BOX*BOX-1:0]    board_blank,
  output logic                          conflict,
  output logic                          req_err,
  output logic                          done
);
  localparam int N     = BOX * BOX;
  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int GW    = $clog2(3 * N);
  localparam logic [GW-1:0] GRP_LAST  = GW'(3 * N - 1);
  localparam logic [31:0]   HOLD_LAST = 32'(HOLD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CHECK, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CELLS-1:0][DW-1:0] cells;
  logic [CELLS-1:0]         blank;
  logic [GW-1:0]            grp;
  logic                     scan_dup, scan_inc;
  logic [31:0]              hold_cnt;

  assign board       = cells;
  assign board_blank = blank;

  logic          wr_fire, wr_range, wr_bad, wr_ok;
  logic [IW-1:0] wr_idx;

  // The blank lookup may alias when out of range; wr_range masks it.
  assign wr_fire  = (state == PLAY) && wr_valid;
  assign wr_range = ({1'b0, wr_row} < 5'(N)) && ({1'b0, wr_col} < 5'(N));
  assign wr_idx   = IW'(int'(wr_row) * N + int'(wr_col));
  assign wr_bad   = !wr_range || !blank[wr_idx] || (int'(wr_data) > N);
  assign wr_ok    = wr_fire && !wr_bad;

  logic          undo_pop, undo_err;
  logic [IW-1:0] pop_idx;
  logic [DW-1:0] pop_val;

`ifdef SUDOKU_UNDO_EN
  localparam int HW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int CW = $clog2(UNDO_DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } hist_t;

  hist_t         hist [UNDO_DEPTH];
  logic [HW-1:0] hptr, hptr_prev;
  logic [CW-1:0] hcnt;
  logic          undo_fire;

  assign undo_fire = (state == PLAY) && undo_req && !wr_valid;
  assign undo_pop  = undo_fire && (hcnt != '0);
  assign undo_err  = undo_fire && (hcnt == '0);
  assign hptr_prev = (hptr == '0) ? HW'(UNDO_DEPTH - 1) : hptr - 1'b1;
  assign pop_idx   = hist[hptr_prev].idx;
  assign pop_val   = hist[hptr_prev].val;

  always_ff @(posedge clk)
    if (wr_ok) hist[hptr] <= {wr_idx, cells[wr_idx]};

  // Ring buffer: a push when full overwrites the oldest entry, count saturates.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hptr <= '0;
      hcnt <= '0;
    end else if (state == LOAD) begin
      hptr <= '0;
      hcnt <= '0;
    end else if (wr_ok) begin
      hptr <= (hptr == HW'(UNDO_DEPTH - 1)) ? '0 : hptr + 1'b1;
      if (hcnt != CW'(UNDO_DEPTH)) hcnt <= hcnt + 1'b1;
    end else if (undo_pop) begin
      hptr <= hptr_prev;
      hcnt <= hcnt - 1'b1;
    end
`else
  logic unused_undo;
  assign unused_undo = undo_req;
  assign undo_pop    = 1'b0;
  assign undo_err    = 1'b0;
  assign pop_idx     = '0;
  assign pop_val     = '0;
`endif

  logic grp_dup, grp_inc, scan_last, hold_last;

  // Group grp: 0..N-1 rows, N..2N-1 columns, 2N..3N-1 boxes.
  always_comb begin
    logic [(1<<DW)-1:0] seen;
    logic [DW-1:0]      v;
    int                 kind, k, r, c;
    seen    = '0;
    v       = '0;
    grp_dup = 1'b0;
    grp_inc = 1'b0;
    kind    = int'(grp) / N;
    k       = int'(grp) % N;
    r       = 0;
    c       = 0;
    for (int j = 0; j < N; j++) begin
      case (kind)
        0:       begin r = k; c = j; end
        1:       begin r = j; c = k; end
        default: begin r = (k / BOX) * BOX + j / BOX; c = (k % BOX) * BOX + j % BOX; end
      endcase
      v = cells[IW'(r * N + c)];
      if (v == '0) grp_inc = 1'b1;
      else begin
        if (seen[v]) grp_dup = 1'b1;
        seen[v] = 1'b1;
      end
    end
    if (grp_dup) grp_inc = 1'b1;
  end

  assign scan_last = (state == CHECK) && (grp == GRP_LAST);
  assign hold_last = (state == DONE) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = CHECK;
      PLAY: begin
        wr_ready = 1'b1;
        if (wr_ok || undo_pop) state_nxt = CHECK;
      end
      CHECK: if (grp == GRP_LAST) state_nxt = (scan_inc || grp_inc) ? PLAY : DONE;
      DONE:  if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cells    <= '0;
      blank    <= '0;
      grp      <= '0;
      scan_dup <= 1'b0;
      scan_inc <= 1'b0;
      hold_cnt <= '0;
      conflict <= 1'b0;
      req_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      req_err  <= (wr_fire && wr_bad) || undo_err;
      done     <= hold_last;
      grp      <= (state == CHECK && !scan_last) ? grp + 1'b1 : '0;
      scan_dup <= (state == CHECK && !scan_last) && (scan_dup || grp_dup);
      scan_inc <= (state == CHECK && !scan_last) && (scan_inc || grp_inc);
      hold_cnt <= (state == DONE && !hold_last) ? hold_cnt + 1'b1 : '0;
      if (scan_last) conflict <= scan_dup || grp_dup;
      case (state)
        LOAD: begin
          cells <= init_board;
          blank <= init_blank;
        end
        PLAY:
          if (wr_ok)         cells[wr_idx]  <= wr_data;
          else if (undo_pop) cells[pop_idx] <= pop_val;
        DONE:
          if (hold_last) begin
            cells <= '0;
            blank <= '0;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sudoku_game_engine.sv
// Scoreboard bench for sudoku_game_engine: a board-level model predicts each response event.
module tb_sudoku_game_engine;
  localparam int BOX = 3, N = 9, CELLS = 81, DW = 4, DEPTH = 2, HOLD = 10;
  localparam int BOX2 = 2, N2 = 4, CELLS2 = 16, DW2 = 3;
`ifdef SUDOKU_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif
  localparam int K_ERR = 0, K_PLAY = 1, K_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst1_n, start, wr_valid, wr_ready, undo_req, conflict, req_err, done;
  logic [3:0]            wr_row, wr_col;
  logic [DW-1:0]         wr_data;
  logic [CELLS*DW-1:0]   init_board, board;
  logic [CELLS-1:0]      init_blank, board_blank;

  logic                  rst2_n, start2, wr_ready2, conflict2, req_err2, done2;
  logic [CELLS2*DW2-1:0] init_board2, board2;
  logic [CELLS2-1:0]     init_blank2, blank2;

  sudoku_game_engine #(.BOX(BOX), .DW(DW), .UNDO_DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .reset(rst1_n), .start(start), .init_board(init_board), .init_blank(init_blank),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .undo_req(undo_req), .board(board), .board_blank(board_blank), .conflict(conflict),
    .req_err(req_err), .done(done));

  sudoku_game_engine #(.BOX(BOX2), .DW(DW2), .UNDO_DEPTH(4), .HOLD(HOLD)) dut2 (
    .clk(clk), .reset(rst2_n), .start(start2), .init_board(init_board2), .init_blank(init_blank2),
    .wr_valid(1'b0), .wr_ready(wr_ready2), .wr_row(4'd0), .wr_col(4'd0), .wr_data(3'd0),
    .undo_req(1'b0), .board(board2), .board_blank(blank2), .conflict(conflict2),
    .req_err(req_err2), .done(done2));

  int checks = 0, passes = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                  kind;
    int                  due;
    logic [CELLS*DW-1:0] brd;
    logic [CELLS-1:0]    blk;
    logic                conf;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: cell values, editable flags, undo history as idx*16+old.
  int mb[CELLS];
  bit mbl[CELLS];
  int hq[$];
  bit game_over = 1'b1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic int pattern(int i, int bx);
    int n = bx * bx;
    int r = i / n, c = i % n;
    return (bx * (r % bx) + r / bx + c) % n + 1;
  endfunction

  function automatic logic [CELLS*DW-1:0] pack_b();
    logic [CELLS*DW-1:0] p = '0;
    for (int i = 0; i < CELLS; i++) p[i*DW +: DW] = DW'(mb[i]);
    return p;
  endfunction

  function automatic logic [CELLS-1:0] pack_k();
    logic [CELLS-1:0] p = '0;
    for (int i = 0; i < CELLS; i++) p[i] = mbl[i];
    return p;
  endfunction

  // Solved = every row, column and box holds each of 1..N exactly once.
  function automatic void evaluate(output bit solved, output bit dup);
    solved = 1'b1;
    dup    = 1'b0;
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < N; k++) begin
        int cnt[N+1];
        foreach (cnt[v]) cnt[v] = 0;
        for (int j = 0; j < N; j++) begin
          int r, c;
          if (t == 0)      begin r = k; c = j; end
          else if (t == 1) begin r = j; c = k; end
          else             begin r = (k / BOX) * BOX + j / BOX; c = (k % BOX) * BOX + j % BOX; end
          cnt[mb[r*N+c]]++;
        end
        if (cnt[0] != 0) solved = 1'b0;
        for (int v = 1; v <= N; v++) begin
          if (cnt[v] > 1)  dup = 1'b1;
          if (cnt[v] != 1) solved = 1'b0;
        end
      end
  endfunction

  task automatic expect_scan(input int t0, input int extra);
    exp_t e;
    bit s, d;
    evaluate(s, d);
    if (s) begin
      foreach (mb[i]) begin mb[i] = 0; mbl[i] = 1'b0; end
      game_over = 1'b1;
      e = '{K_DONE, t0 + 3*N + extra + HOLD, '0, '0, 1'b0};
    end else
      e = '{K_PLAY, t0 + 3*N + extra, pack_b(), pack_k(), d};
    exp_q.push_back(e);
  endtask

  task automatic got_event(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got event kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.due);
    chk("board", board, e.brd);
    chk("board_blank", board_blank, e.blk);
    if (kind == K_PLAY) chk("conflict", conflict, e.conf);
  endtask

  bit prev_ready = 1'b0;
  always @(negedge clk) begin
    if (rst1_n) begin
      if (req_err)                 got_event(K_ERR);
      if (wr_ready && !prev_ready) got_event(K_PLAY);
      if (done)                    got_event(K_DONE);
    end
    prev_ready = wr_ready;
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL timeout: %0d responses outstanding after 200 cycles, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic load_game(input logic [CELLS-1:0] mask);
    for (int i = 0; i < CELLS; i++) begin
      mbl[i] = mask[i];
      mb[i]  = mask[i] ? 0 : pattern(i, BOX);
    end
    init_board = pack_b();
    init_blank = mask;
    hq.delete();
    game_over = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    expect_scan(cyc, 1);
    wait_idle();
  endtask

  task automatic do_write(input int r, input int c, input int d, input bit also_undo);
    @(negedge clk);
    wr_valid = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_data = DW'(d); undo_req = also_undo;
    @(posedge clk); #1 wr_valid = 1'b0; undo_req = 1'b0;
    if (r >= N || c >= N || !mbl[r*N+c] || d > N)
      exp_q.push_back('{K_ERR, cyc, pack_b(), pack_k(), 1'b0});
    else begin
      if (UNDO_EN) begin
        if (hq.size() == DEPTH) void'(hq.pop_front());
        hq.push_back((r*N+c) * 16 + mb[r*N+c]);
      end
      mb[r*N+c] = d;
      expect_scan(cyc, 0);
    end
    wait_idle();
  endtask

  task automatic do_undo();
    @(negedge clk); undo_req = 1'b1;
    @(posedge clk); #1 undo_req = 1'b0;
    if (!UNDO_EN) begin
      repeat (3) @(posedge clk);
      #1;
      chk("undo_ignored_board", board, pack_b());
      chk("undo_ignored_ready", wr_ready, 1'b1);
    end else if (hq.size() == 0)
      exp_q.push_back('{K_ERR, cyc, pack_b(), pack_k(), 1'b0});
    else begin
      int e = hq.pop_back();
      mb[e/16] = e % 16;
      expect_scan(cyc, 0);
    end
    wait_idle();
  endtask

  task automatic write_blank(input bit also_undo);
    int bl[$];
    int i;
    for (int j = 0; j < CELLS; j++) if (mbl[j]) bl.push_back(j);
    i = (bl.size() != 0) ? bl[$urandom_range(0, bl.size() - 1)] : 0;
    do_write(i / N, i % N, $urandom_range(0, N), also_undo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CELLS-1:0] mask;
    int t;
    rst1_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
    wr_valid = 1'b0; undo_req = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    init_board = '0; init_blank = '0; init_board2 = '0; init_blank2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_board", board, '0);
    chk("reset_blank", board_blank, '0);
    chk("reset_conflict", conflict, 1'b0);
    chk("reset_req_err", req_err, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_wr_ready", wr_ready, 1'b0);
    @(negedge clk); rst1_n = 1'b1; rst2_n = 1'b1;

    // One blank cell, then the correct value finishes the game.
    mask = '0; mask[0] = 1'b1;
    load_game(mask);
    do_write(0, 0, 1, 1'b0);

    mask = '0; mask[0] = 1'b1; mask[10] = 1'b1; mask[20] = 1'b1; mask[30] = 1'b1;
    load_game(mask);
    do_write(0, 0, 5, 1'b0);
    do_undo();
    do_write(0, 4, 3, 1'b0);
    do_write(9, 0, 1, 1'b0);
    do_write(1, 1, 10, 1'b0);
    do_write(0, 0, 1, 1'b0);
    do_write(1, 1, 5, 1'b0);
    do_write(2, 2, 9, 1'b0);
    do_undo();
    do_undo();
    do_undo();
    do_write(3, 3, 2, 1'b1);
    do_undo();

    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("start_ignored_ready", wr_ready, 1'b1);
    chk("start_ignored_board", board, pack_b());

    for (int it = 0; it < 60; it++) begin
      int op = $urandom_range(0, 99);
      if (game_over) begin
        mask = '0;
        repeat (6) mask[$urandom_range(0, CELLS - 1)] = 1'b1;
        load_game(mask);
      end else if (op < 55) write_blank(1'b0);
      else if (op < 70) do_write($urandom_range(0, 10), $urandom_range(0, N - 1), $urandom_range(0, N + 1), 1'b0);
      else if (op < 85) do_undo();
      else write_blank(1'b1);
    end

    // Second engine: reset in the middle of a scan.
    for (int i = 0; i < CELLS2; i++) init_board2[i*DW2 +: DW2] = DW2'(i == 0 ? 0 : pattern(i, BOX2));
    init_blank2 = 16'h0001;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("dut2_loaded", board2 != '0, 1'b1);
    rst2_n = 1'b0;
    #1;
    chk("dut2_rst_board", board2, '0);
    chk("dut2_rst_blank", blank2, '0);
    chk("dut2_rst_conflict", conflict2, 1'b0);
    chk("dut2_rst_req_err", req_err2, 1'b0);
    chk("dut2_rst_done", done2, 1'b0);
    chk("dut2_rst_wr_ready", wr_ready2, 1'b0);
    @(negedge clk); rst2_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("dut2_idle_ready", wr_ready2, 1'b0);
    chk("dut2_idle_board", board2, '0);
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    t = cyc;
    for (int n = 0; n < 40 && !wr_ready2; n++) @(negedge clk);
    chk("dut2_restart_latency", cyc - t, 3 * N2 + 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
